// File: rtl/dmem_arbiter_if.sv
// Bundle of the two requester ports and the data-memory bus around dmem_arbiter.
// lock0 exists only when DMEM_ARB_LOCK_EN is defined.
interface dmem_arbiter_if #(
    parameter int AW = 16,
    parameter int DW = 16
);
    logic          req0;
    logic          we0;
    logic [AW-1:0] addr0;
    logic [DW-1:0] wdata0;
    logic          ack0;
    logic [DW-1:0] rdata0;
    logic          req1;
    logic          we1;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata1;
    logic          ack1;
    logic [DW-1:0] rdata1;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic          grant_id;
`ifdef DMEM_ARB_LOCK_EN
    logic          lock0;
`endif

    // Arbiter side
    modport slave (
`ifdef DMEM_ARB_LOCK_EN
        input  lock0,
`endif
        input  req0, we0, addr0, wdata0,
        input  req1, we1, addr1, wdata1,
        input  mem_rdata,
        output ack0, rdata0, ack1, rdata1,
        output mem_we, mem_addr, mem_wdata,
        output busy, grant_id
    );

    // Requester / memory-model side
    modport master (
`ifdef DMEM_ARB_LOCK_EN
        output lock0,
`endif
        output req0, we0, addr0, wdata0,
        output req1, we1, addr1, wdata1,
        output mem_rdata,
        input  ack0, rdata0, ack1, rdata1,
        input  mem_we, mem_addr, mem_wdata,
        input  busy, grant_id
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for the single-port data memory (IDLE -> ACCESS -> RESP).
// Optional DMEM_ARB_LOCK_EN adds lock0 so port 0 can hold the memory across back-to-back transactions.
module dmem_arbiter #(
    parameter int AW = 16,
    parameter int DW = 16
) (
    input  logic            clk,
    input  logic            rst,
    dmem_arbiter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t        state, state_nxt;
    logic          rr_ptr;
    logic          grant_id;
    logic          lat_we;
    logic          grant;
    logic          win;
    logic [AW-1:0] mem_addr_q;
    logic [DW-1:0] mem_wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;
`ifdef DMEM_ARB_LOCK_EN
    logic          lock_q;
`endif

    always_comb begin
        state_nxt = state;
        grant     = 1'b0;
        win       = rr_ptr;
        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    grant = 1'b1;
                    win   = rr_ptr;
                end else if (bus.req0) begin
                    grant = 1'b1;
                    win   = 1'b0;
                end else if (bus.req1) begin
                    grant = 1'b1;
                    win   = 1'b1;
                end
`ifdef DMEM_ARB_LOCK_EN
                // A locked port 0 wins regardless of the pointer or port 1
                if (lock_q && bus.req0) win = 1'b0;
`endif
                if (grant) state_nxt = ACCESS;
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            grant_id    <= 1'b0;
            lat_we      <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            rdata0_q    <= '0;
            rdata1_q    <= '0;
`ifdef DMEM_ARB_LOCK_EN
            lock_q      <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (grant) begin
                grant_id    <= win;
                lat_we      <= win ? bus.we1    : bus.we0;
                mem_addr_q  <= win ? bus.addr1  : bus.addr0;
                mem_wdata_q <= win ? bus.wdata1 : bus.wdata0;
`ifdef DMEM_ARB_LOCK_EN
                lock_q      <= 1'b0;
`endif
            end
            if (state == ACCESS && !lat_we) begin
                if (grant_id) rdata1_q <= bus.mem_rdata;
                else          rdata0_q <= bus.mem_rdata;
            end
            if (state == RESP) begin
`ifdef DMEM_ARB_LOCK_EN
                if (!grant_id && bus.lock0) lock_q <= 1'b1;
                else                        rr_ptr <= ~grant_id;
`else
                rr_ptr <= ~grant_id;
`endif
            end
        end
    end

    // Strobe and acks decode straight from state so reset removes them at once
    assign bus.mem_we    = (state == ACCESS) && lat_we;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.ack0      = (state == RESP) && !grant_id;
    assign bus.ack1      = (state == RESP) &&  grant_id;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.busy      = (state != IDLE);
    assign bus.grant_id  = grant_id;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 256-word combinational-read memory model.
module tb_dmem_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   we_cnt;
    logic [15:0] mem [0:255];

    dmem_arbiter_if #(.AW(16), .DW(16)) bus ();

    dmem_arbiter #(.AW(16), .DW(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    assign bus.mem_rdata = mem[bus.mem_addr[7:0]];

    always @(posedge clk) begin
        if (bus.mem_we) mem[bus.mem_addr[7:0]] <= bus.mem_wdata;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 16'h0000;
        mem[1] = 16'h1111;
        mem[2] = 16'h2222;
        bus.req0 = 1'b0; bus.we0 = 1'b0; bus.addr0 = '0; bus.wdata0 = '0;
        bus.req1 = 1'b0; bus.we1 = 1'b0; bus.addr1 = '0; bus.wdata1 = '0;
`ifdef DMEM_ARB_LOCK_EN
        bus.lock0 = 1'b0;
`endif
        repeat (2) @(negedge clk);

        // Reset values
        check("rst_ack0", bus.ack0, 0);
        check("rst_ack1", bus.ack1, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_grant_id", bus.grant_id, 0);
        check("rst_rdata0", bus.rdata0, 0);
        check("rst_rdata1", bus.rdata1, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        rst = 1'b1;
        @(negedge clk);

        // Port 0 write 0xBEEF to 0x0010
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0010; bus.wdata0 = 16'hBEEF;
        @(negedge clk);
        check("t1_acc_mem_we", bus.mem_we, 1);
        check("t1_acc_mem_addr", bus.mem_addr, 16'h0010);
        check("t1_acc_mem_wdata", bus.mem_wdata, 16'hBEEF);
        check("t1_acc_busy", bus.busy, 1);
        check("t1_acc_ack0", bus.ack0, 0);
        @(negedge clk);
        check("t1_resp_ack0", bus.ack0, 1);
        check("t1_resp_ack1", bus.ack1, 0);
        check("t1_resp_mem_we", bus.mem_we, 0);
        check("t1_resp_grant_id", bus.grant_id, 0);
        bus.req0 = 1'b0;
        @(negedge clk);
        check("t1_idle_ack0", bus.ack0, 0);
        check("t1_idle_busy", bus.busy, 0);
        check("t1_idle_addr_hold", bus.mem_addr, 16'h0010);
        check("t1_mem_written", mem[16], 16'hBEEF);

        // Port 1 read back 0x0010
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0010;
        @(negedge clk);
        check("t2_acc_mem_we", bus.mem_we, 0);
        check("t2_acc_grant_id", bus.grant_id, 1);
        @(negedge clk);
        check("t2_ack1", bus.ack1, 1);
        check("t2_ack0", bus.ack0, 0);
        check("t2_rdata1", bus.rdata1, 16'hBEEF);
        check("t2_rdata0", bus.rdata0, 0);
        bus.req1 = 1'b0;
        @(negedge clk);

        // Contention: both ports reading, grants alternate 0,1,0,1
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0001;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0002;
        for (int c = 1; c <= 11; c++) begin
            @(negedge clk);
            check("t3_ack0", bus.ack0, (c % 6) == 2);
            check("t3_ack1", bus.ack1, (c % 6) == 5);
            check("t3_overlap", bus.ack0 & bus.ack1, 0);
            if ((c % 3) == 1) check("t3_grant_id", bus.grant_id, (c % 6) == 4);
            if ((c % 6) == 2) check("t3_rdata0", bus.rdata0, 16'h1111);
            if ((c % 6) == 5) check("t3_rdata1", bus.rdata1, 16'h2222);
            if (c == 8)  bus.req0 = 1'b0;
            if (c == 11) bus.req1 = 1'b0;
        end
        @(negedge clk);
        check("t3_idle_busy", bus.busy, 0);

        // Port 0 request pulsed for one cycle only
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0003; bus.wdata0 = 16'h1234;
        we_cnt = 0;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            we_cnt += int'(bus.mem_we);
            if (c == 1) check("t4_acc_mem_addr", bus.mem_addr, 16'h0003);
            check("t4_ack0", bus.ack0, c == 2);
            check("t4_busy", bus.busy, c <= 2);
            if (c == 1) bus.req0 = 1'b0;
        end
        check("t4_we_pulses", we_cnt, 1);
        check("t4_mem_written", mem[3], 16'h1234);
        check("t4_rdata0_kept", bus.rdata0, 16'h1111);

        // Reset asserted during ACCESS of a write
        bus.req0 = 1'b1; bus.we0 = 1'b1; bus.addr0 = 16'h0005; bus.wdata0 = 16'h5555;
        @(negedge clk);
        check("t5_acc_mem_we", bus.mem_we, 1);
        #1 rst = 1'b0;
        #1;
        check("t5_async_mem_we", bus.mem_we, 0);
        check("t5_async_busy", bus.busy, 0);
        check("t5_async_ack0", bus.ack0, 0);
        check("t5_async_mem_addr", bus.mem_addr, 0);
        check("t5_async_mem_wdata", bus.mem_wdata, 0);
        check("t5_async_rdata0", bus.rdata0, 0);
        check("t5_async_rdata1", bus.rdata1, 0);
        check("t5_async_grant_id", bus.grant_id, 0);
        bus.req0 = 1'b0;
        @(negedge clk);
        check("t5_no_ack0", bus.ack0, 0);
        check("t5_no_write", mem[5], 0);
        rst = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0001;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0002;
        @(negedge clk);
        check("t5_first_grant", bus.grant_id, 0);
        check("t5_busy", bus.busy, 1);
        @(negedge clk);
        check("t5_ack0", bus.ack0, 1);
        check("t5_ack1_low", bus.ack1, 0);
        check("t5_rdata0", bus.rdata0, 16'h1111);
        bus.req0 = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_second_grant", bus.grant_id, 1);
        @(negedge clk);
        check("t5_ack1", bus.ack1, 1);
        check("t5_rdata1", bus.rdata1, 16'h2222);
        bus.req1 = 1'b0;
        @(negedge clk);
        check("t5_idle_busy", bus.busy, 0);

`ifdef DMEM_ARB_LOCK_EN
        // Locked port 0 keeps the memory until lock0 drops
        bus.lock0 = 1'b1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 16'h0001;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 16'h0002;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check("lk_ack0", bus.ack0, (c == 2) || (c == 5));
            check("lk_ack1", bus.ack1, c == 8);
            if (c == 4) bus.lock0 = 1'b0;
            if (c == 8) begin
                bus.req0 = 1'b0;
                bus.req1 = 1'b0;
            end
        end
        @(negedge clk);
        check("lk_idle_busy", bus.busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-requester arbiter and sequencer for the single-port 16-bit data memory.
- Port 0 is the CPU load/store path, driven by the control unit in the MEM cycle. Port 1 is the debug/display readback and preload path.
- Serialises accesses, drives the memory's write strobe for exactly one cycle per write, registers read data, and returns a one-cycle ack per transaction.

Parameters:
- AW, 16, address width in bits.
- DW, 16, data width in bits.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0  input  1  port 0 request; held high until ack0.
- we0  input  1  port 0 write (1) / read (0); sampled at grant.
- addr0  input  AW  port 0 address; sampled at grant.
- wdata0  input  DW  port 0 write data; sampled at grant.
- ack0  output  1  one-cycle completion pulse for port 0.
- rdata0  output  DW  port 0 read data; valid with ack0, held until the next port 0 read completes.
- req1, we1, addr1, wdata1, ack1, rdata1: same as port 0, for port 1.
- mem_we  output  1  memory write strobe.
- mem_addr  output  AW  memory address.
- mem_wdata  output  DW  memory write data.
- mem_rdata  input  DW  memory read data; combinational from mem_addr.
- busy  output  1  high in ACCESS and RESP.
- grant_id  output  1  port owning the current or last transaction.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, rr_ptr=0 (port 0 preferred first).
  - ack0=ack1=0, mem_we=0, busy=0, grant_id=0.
  - rdata0=rdata1=0, mem_addr=0, mem_wdata=0.
- FSM states IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One req high: grant that port.
  - Both high: grant the port selected by rr_ptr.
  - On grant: latch we/addr/wdata of the winner into internal registers, set grant_id, go to ACCESS.
- ACCESS (exactly one cycle):
  - mem_addr and mem_wdata come from the latched registers.
  - mem_we = latched we, asserted only in this state.
  - If read: capture mem_rdata into rdataN at the end of the cycle.
  - Go to RESP.
- RESP (exactly one cycle):
  - ackN=1 for the granted port only.
  - rr_ptr := ~grant_id.
  - Go to IDLE.
- Latency: req sampled high at edge N → ACCESS during cycle N+1 → ack high during cycle N+2. Throughput is one transaction per 3 cycles.
- Handshake:
  - The requester keeps req and its fields stable until ack, then drops req the cycle after ack.
  - If req is still high in IDLE after RESP, a new transaction is started. This is the legal back-to-back mode.
- req dropped after grant: the transaction still completes and ack is still pulsed.
- Only one ack is high in any cycle. The ack for one port never depends on the other port's req.
- The non-granted port waits with no limit. Round-robin bounds its wait to one transaction (≤3 cycles) under continuous contention.
- mem_addr/mem_wdata hold their last values outside ACCESS. mem_we is 0 outside ACCESS.
- Write transactions leave rdataN unchanged.
- Reset asserted mid-transaction: mem_we drops immediately, no ack is issued, and the FSM returns to IDLE. Requesters must re-issue.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- With the macro defined:
  - Extra input port lock0 (1 bit).
  - If lock0 is high when port 0's RESP completes and req0 is high in the next IDLE, port 0 is granted regardless of rr_ptr and req1.
  - rr_ptr is not advanced while locked.
  - Used for CPU read-modify-write sequences.
- Without the macro: no lock0 port; pure round-robin as above.

Test Plan:
- Reset, then req0=1, we0=1, addr0=0x0010, wdata0=0xBEEF → mem_we=1 for exactly one cycle with mem_addr=0x0010, mem_wdata=0xBEEF; ack0 pulses 2 cycles after the request edge; ack1 stays 0.
- After the test-1 write, with memory model holding 0xBEEF at 0x0010: req1=1, we1=0, addr1=0x0010 → ack1 pulse with rdata1=0xBEEF, mem_we stays 0, rdata0 unchanged.
- req0 and req1 raised on the same edge and held through repeated acks (reads at 0x0001 / 0x0002) → grants alternate 0,1,0,1; ack0/ack1 never overlap; each port completes every 6 cycles.
- req0 pulsed for one cycle only (write 0x1234 to 0x0003) → transaction still completes, mem_we pulses once, ack0 pulses once, FSM returns to IDLE and stays there.
- rst driven low during ACCESS of a write → mem_we falls asynchronously, no ack; after release, all outputs are at their reset values and rr_ptr prefers port 0.
- With DMEM_ARB_LOCK_EN: lock0=1, req0 and req1 both held → port 0 granted consecutively; after lock0=0, the next grant goes to port 1.
